// File: rtl/unroller_pkg.sv
// Shared helpers for the unroller slice.
//  cnt_w : width of a beat counter that walks 0..depth-1 (never narrower than 1 bit,
//          so DEPTH==1 configurations still have a legal counter).
//  hs_t  : per-cycle handshake events decoded once in the top level.
package unroller_pkg;

  function automatic int cnt_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef struct packed {
    logic in_fire;    // input beat accepted this cycle
    logic out_fire;   // output vector consumed this cycle
    logic last_beat;  // accepted beat (if any) completes the vector
  } hs_t;

endpackage

// File: rtl/unroller_bank.sv
// One NUM-element register bank with an indexed beat write.
//  clk      : clock
//  rst      : synchronous active-high reset, clears all elements
//  wr_en    : write the beat at slot wr_idx
//  wr_idx   : beat slot; elements wr_idx*IN_SIZE .. wr_idx*IN_SIZE+IN_SIZE-1
//  wr_data  : IN_SIZE-element beat
//  q        : full NUM-element contents
module unroller_bank
  import unroller_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM        = 8,
  parameter int IN_SIZE    = 2,
  parameter int CNT_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [CNT_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data [IN_SIZE-1:0],
  output logic [DATA_WIDTH-1:0] q       [NUM-1:0]
);

  // Element i belongs to beat slot i/IN_SIZE, lane i%IN_SIZE.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM; i++) q[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM; i++)
        if (wr_idx == CNT_W'(i / IN_SIZE)) q[i] <= wr_data[i % IN_SIZE];
    end
  end

endmodule

// File: rtl/unroller.sv
// Gathers IN_SIZE-element beats into one NUM-element vector (inverse of the roller).
// Two banks ping-pong so a finished vector can wait on the consumer while the next fills.
//  clk            : clock
//  rst            : synchronous active-high reset; drops partial and pending vectors
//  data_in        : input beat, element 0 of beat 0 lands in data_out[0]
//  data_in_valid  : beat present
//  data_in_ready  : bank under fill is free (register-derived only)
//  data_out       : gathered vector, stable while valid && !ready
//  data_out_valid : vector present
//  data_out_ready : vector consumed when valid && ready
module unroller
  import unroller_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM        = 8,
  parameter int IN_SIZE    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in [IN_SIZE-1:0],
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out [NUM-1:0],
  output logic                  data_out_valid,
  input  logic                  data_out_ready
);

  localparam int DEPTH = NUM / IN_SIZE;
  localparam int CNT_W = cnt_w(DEPTH);

  if (NUM % IN_SIZE != 0) begin : g_bad_cfg
    $error("unroller: NUM must be a multiple of IN_SIZE");
  end

  logic [1:0]            full, full_nxt;
  logic                  wr_sel, wr_sel_nxt;
  logic                  rd_sel, rd_sel_nxt;
  logic [CNT_W-1:0]      wr_cnt, wr_cnt_nxt;
  hs_t                   hs;
  logic [DATA_WIDTH-1:0] bank_q [1:0][NUM-1:0];

  assign data_in_ready  = !full[wr_sel];
  assign data_out_valid = full[rd_sel];

  assign hs.in_fire   = data_in_valid && data_in_ready;
  assign hs.out_fire  = data_out_valid && data_out_ready;
  assign hs.last_beat = (wr_cnt == CNT_W'(DEPTH - 1));

  for (genvar b = 0; b < 2; b++) begin : g_bank
    unroller_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM        (NUM),
      .IN_SIZE    (IN_SIZE),
      .CNT_W      (CNT_W)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (hs.in_fire && (wr_sel == 1'(b))),
      .wr_idx  (wr_cnt),
      .wr_data (data_in),
      .q       (bank_q[b])
    );
  end

  always_comb begin
    for (int i = 0; i < NUM; i++) data_out[i] = bank_q[rd_sel][i];
  end

  // Fill and drain always target different banks (a bank is only read once full
  // and only written while empty), so both full-bit updates can land together.
  always_comb begin
    full_nxt   = full;
    wr_sel_nxt = wr_sel;
    rd_sel_nxt = rd_sel;
    wr_cnt_nxt = wr_cnt;
    if (hs.out_fire) begin
      full_nxt[rd_sel] = 1'b0;
      rd_sel_nxt       = !rd_sel;
    end
    if (hs.in_fire) begin
      if (hs.last_beat) begin
        wr_cnt_nxt       = '0;
        full_nxt[wr_sel] = 1'b1;
        wr_sel_nxt       = !wr_sel;
      end else begin
        wr_cnt_nxt = wr_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full   <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      wr_cnt <= '0;
    end else begin
      full   <= full_nxt;
      wr_sel <= wr_sel_nxt;
      rd_sel <= rd_sel_nxt;
      wr_cnt <= wr_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_unroller.sv
module tb_unroller;
  localparam int DW   = 16;
  localparam int NUM  = 8;
  localparam int INS  = 2;
  localparam int NUM1 = 2;
  localparam int INS1 = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main instance (DEPTH=4)
  logic [DW-1:0] din  [INS-1:0];
  logic          din_v, din_r;
  logic [DW-1:0] dout [NUM-1:0];
  logic          dout_v, dout_r;

  // DEPTH=1 instance
  logic [DW-1:0] din1  [INS1-1:0];
  logic          din1_v, din1_r;
  logic [DW-1:0] dout1 [NUM1-1:0];
  logic          dout1_v, dout1_r;

  unroller #(.DATA_WIDTH(DW), .NUM(NUM), .IN_SIZE(INS)) dut (
    .clk(clk), .rst(rst),
    .data_in(din), .data_in_valid(din_v), .data_in_ready(din_r),
    .data_out(dout), .data_out_valid(dout_v), .data_out_ready(dout_r)
  );

  unroller #(.DATA_WIDTH(DW), .NUM(NUM1), .IN_SIZE(INS1)) dut1 (
    .clk(clk), .rst(rst),
    .data_in(din1), .data_in_valid(din1_v), .data_in_ready(din1_r),
    .data_out(dout1), .data_out_valid(dout1_v), .data_out_ready(dout1_r)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the stream of accepted elements in arrival order.
  // Every emitted vector must be exactly the next NUM elements of that stream.
  logic [DW-1:0] sb  [$];
  logic [DW-1:0] sb1 [$];

  // per-cycle observations (sampled on the falling edge)
  logic                in_hs, out_hs, obs_v, obs_r, obs_in_r;
  logic [NUM*DW-1:0]   obs_flat;
  logic                in1_hs, out1_hs, obs1_v, obs1_r, obs1_in_r;
  logic [NUM1*DW-1:0]  obs1_flat;

  function automatic logic [NUM*DW-1:0] pop_exp();
    logic [NUM*DW-1:0] v;
    v = '0;
    for (int i = 0; i < NUM; i++)
      if (sb.size() > 0) v[i*DW +: DW] = sb.pop_front();
      else               v[i*DW +: DW] = 'x;
    return v;
  endfunction

  function automatic logic [NUM1*DW-1:0] pop_exp1();
    logic [NUM1*DW-1:0] v;
    v = '0;
    for (int i = 0; i < NUM1; i++)
      if (sb1.size() > 0) v[i*DW +: DW] = sb1.pop_front();
      else                v[i*DW +: DW] = 'x;
    return v;
  endfunction

  // Sample both DUTs mid-cycle, record accepted beats, then advance to just after the next edge.
  task automatic tick();
    @(negedge clk);
    in_hs    = din_v && din_r;
    out_hs   = dout_v && dout_r;
    obs_v    = dout_v;
    obs_r    = dout_r;
    obs_in_r = din_r;
    for (int i = 0; i < NUM; i++) obs_flat[i*DW +: DW] = dout[i];
    if (in_hs) for (int j = 0; j < INS; j++) sb.push_back(din[j]);
    in1_hs    = din1_v && din1_r;
    out1_hs   = dout1_v && dout1_r;
    obs1_v    = dout1_v;
    obs1_r    = dout1_r;
    obs1_in_r = din1_r;
    for (int i = 0; i < NUM1; i++) obs1_flat[i*DW +: DW] = dout1[i];
    if (in1_hs) for (int j = 0; j < INS1; j++) sb1.push_back(din1[j]);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_beat();
    for (int j = 0; j < INS; j++) din[j] = 16'($urandom());
  endtask

  task automatic rand_beat1();
    for (int j = 0; j < INS1; j++) din1[j] = 16'($urandom());
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    checks++; if (obs_v !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", obs_v); end
    checks++; if (obs_flat !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", obs_flat); end
    checks++; if (obs_in_r !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", obs_in_r); end
    checks++; if (obs1_v !== 1'b0 || obs1_in_r !== 1'b1 || obs1_flat !== '0) begin
      errors++; $display("FAIL reset_depth1: valid %b ready %b data %h want 0 1 0", obs1_v, obs1_in_r, obs1_flat);
    end
  endtask

  task automatic test_basic();
    logic [NUM*DW-1:0] exp;
    for (int i = 0; i < NUM; i++) exp[i*DW +: DW] = 16'(i + 1);
    dout_r = 1'b1;
    for (int b = 0; b < 4; b++) begin
      din[0] = 16'(2*b + 1);
      din[1] = 16'(2*b + 2);
      din_v  = 1'b1;
      tick();
      checks++; if (!in_hs || obs_v) begin
        errors++; $display("FAIL basic_beat%0d: accepted %b valid %b want 1 0", b, in_hs, obs_v);
      end
    end
    din_v = 1'b0;
    tick();
    checks++; if (obs_v !== 1'b1) begin errors++; $display("FAIL basic_latency: valid %b want 1", obs_v); end
    checks++; if (obs_flat !== exp) begin errors++; $display("FAIL basic_data: got %h want %h", obs_flat, exp); end
    tick();
    checks++; if (obs_v !== 1'b0) begin errors++; $display("FAIL basic_drop: valid %b want 0", obs_v); end
    sb.delete();
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int vecs = 0;
    int unstable = 0;
    logic pv, pr;
    logic [NUM*DW-1:0] pf, exp;
    pv = 1'b0; pr = 1'b0; pf = '0;
    dout_r = 1'b0;
    rand_beat();
    din_v = 1'b1;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (pv && !pr && (!obs_v || obs_flat !== pf)) unstable++;
      pv = obs_v; pr = obs_r; pf = obs_flat;
      if (in_hs) begin sent++; rand_beat(); end
    end
    checks++; if (sent != 8) begin errors++; $display("FAIL bp_accepted: got %0d want 8", sent); end
    checks++; if (obs_in_r !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", obs_in_r); end
    checks++; if (obs_v !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", obs_v); end
    checks++; if (unstable != 0) begin errors++; $display("FAIL bp_hold: %0d unstable cycles want 0", unstable); end
    dout_r = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (sent >= 12) din_v = 1'b0;
      tick();
      if (in_hs) begin sent++; rand_beat(); end
      if (out_hs) begin
        exp = pop_exp();
        vecs++;
        checks++; if (obs_flat !== exp) begin errors++; $display("FAIL bp_vec%0d: got %h want %h", vecs, obs_flat, exp); end
      end
    end
    checks++; if (vecs != 3 || sent != 12 || sb.size() != 0) begin
      errors++; $display("FAIL bp_totals: vecs %0d beats %0d left %0d want 3 12 0", vecs, sent, sb.size());
    end
  endtask

  task automatic test_full_rate();
    int miss = 0;
    int vecs = 0;
    logic [NUM*DW-1:0] exp;
    dout_r = 1'b1;
    din_v  = 1'b1;
    rand_beat();
    for (int c = 0; c < 67; c++) begin
      if (c == 64) din_v = 1'b0;
      tick();
      if (c < 64 && !in_hs) miss++;
      if (in_hs) rand_beat();
      if (out_hs) begin
        exp = pop_exp();
        vecs++;
        checks++; if (obs_flat !== exp) begin errors++; $display("FAIL rate_vec%0d: got %h want %h", vecs, obs_flat, exp); end
      end
    end
    checks++; if (miss != 0) begin errors++; $display("FAIL rate_in_ready: %0d stalled cycles want 0", miss); end
    checks++; if (vecs != 16 || sb.size() != 0) begin
      errors++; $display("FAIL rate_totals: vecs %0d left %0d want 16 0", vecs, sb.size());
    end
  endtask

  task automatic test_random_stall();
    int unstable = 0;
    logic pv, pr;
    logic [NUM*DW-1:0] pf, exp;
    pv = 1'b0; pr = 1'b0; pf = '0;
    rand_beat();
    for (int c = 0; c < 305; c++) begin
      if (c < 300) begin
        din_v  = ($urandom_range(0, 3) != 0);
        dout_r = ($urandom_range(0, 1) != 0);
      end else begin
        din_v  = 1'b0;
        dout_r = 1'b1;
      end
      tick();
      if (pv && !pr && (!obs_v || obs_flat !== pf)) unstable++;
      pv = obs_v; pr = obs_r; pf = obs_flat;
      if (in_hs) rand_beat();
      if (out_hs) begin
        exp = pop_exp();
        checks++; if (obs_flat !== exp) begin errors++; $display("FAIL stall_vec: got %h want %h", obs_flat, exp); end
      end
    end
    checks++; if (unstable != 0) begin errors++; $display("FAIL stall_hold: %0d unstable cycles want 0", unstable); end
    checks++; if (sb.size() >= NUM) begin errors++; $display("FAIL stall_drain: %0d elements stuck want <%0d", sb.size(), NUM); end
  endtask

  task automatic test_reset_mid();
    int early = 0;
    logic [NUM*DW-1:0] exp;
    for (int i = 0; i < NUM; i++) exp[i*DW +: DW] = 16'(i + 9);
    din_v = 1'b0; dout_r = 1'b1;
    rst = 1'b1; tick(); rst = 1'b0;
    sb.delete();
    din_v = 1'b1;
    for (int b = 0; b < 2; b++) begin rand_beat(); tick(); if (obs_v) early++; end
    din_v = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    sb.delete();
    for (int c = 0; c < 3; c++) begin tick(); if (obs_v) early++; end
    for (int b = 0; b < 4; b++) begin
      din[0] = 16'(2*b + 9);
      din[1] = 16'(2*b + 10);
      din_v  = 1'b1;
      tick();
      if (obs_v) early++;
    end
    din_v = 1'b0;
    tick();
    checks++; if (early != 0) begin errors++; $display("FAIL rstmid_spurious: %0d valid cycles want 0", early); end
    checks++; if (obs_v !== 1'b1 || obs_flat !== exp) begin
      errors++; $display("FAIL rstmid_data: valid %b got %h want 1 %h", obs_v, obs_flat, exp);
    end
    tick();
    sb.delete();
  endtask

  task automatic test_depth1();
    int vecs = 0;
    logic [NUM1*DW-1:0] exp;
    dout1_r = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rand_beat1();
      din1_v = 1'b1;
      tick();
      din1_v = 1'b0;
      exp = {din1[1], din1[0]};
      tick();
      checks++; if (obs1_v !== 1'b1 || obs1_flat !== exp) begin
        errors++; $display("FAIL d1_beat%0d: valid %b got %h want 1 %h", k, obs1_v, obs1_flat, exp);
      end
      sb1.delete();
    end
    rand_beat1();
    for (int c = 0; c < 205; c++) begin
      if (c < 200) begin
        din1_v  = ($urandom_range(0, 1) != 0);
        dout1_r = ($urandom_range(0, 2) != 0);
      end else begin
        din1_v  = 1'b0;
        dout1_r = 1'b1;
      end
      tick();
      if (in1_hs) rand_beat1();
      if (out1_hs) begin
        exp = pop_exp1();
        vecs++;
        checks++; if (obs1_flat !== exp) begin errors++; $display("FAIL d1_vec%0d: got %h want %h", vecs, obs1_flat, exp); end
      end
    end
    checks++; if (vecs == 0 || sb1.size() != 0) begin
      errors++; $display("FAIL d1_drain: vecs %0d left %0d want >0 0", vecs, sb1.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    din_v = 1'b0;  dout_r = 1'b0;
    din1_v = 1'b0; dout1_r = 1'b0;
    for (int j = 0; j < INS; j++)  din[j]  = '0;
    for (int j = 0; j < INS1; j++) din1[j] = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_full_rate();
    test_random_stall();
    test_reset_mid();
    test_depth1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
